// File: rtl/uart_harness_pkg.sv
// uart_harness_pkg: shared FSM states, command field positions and helpers
package uart_harness_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_WDATA_H,
        S_WDATA_L,
        S_RD_SEND,
        S_ACK_SEND
    } state_t;

    localparam int CMD_RW_BIT  = 7;
    localparam int CMD_LEN_MSB = 3;
    localparam int CMD_LEN_LSB = 0;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hA5;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/uart_harness_phy.sv
// uart_harness_phy: serial RX/TX character engine with even parity and selectable bit order
module uart_harness_phy
    import uart_harness_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       parity_en,
    input  logic       msb_first,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [7:0] rx_data
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [2:0]    sync;
    logic          rx_act, rx_pe, rx_msb, rx_par, rx_s, rx_fall, rx_stop, rx_ok;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;

    logic          tx_act;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit, tx_nb;
    logic [10:0]   tx_sh;

    assign rx_s     = sync[1];
    assign rx_fall  = sync[2] & ~sync[1];
    assign rx_stop  = rx_bit == (rx_pe ? 4'd10 : 4'd9);
    assign rx_ok    = rx_s && (!rx_pe || rx_par == ^rx_sh);
    assign rx_data  = rx_sh;

    assign txd      = tx_sh[0];
    assign tx_done  = tx_act && tx_cnt == LAST && tx_bit == tx_nb;
    assign tx_ready = !tx_act || tx_done;

    // receiver: sync, start detect with mid-bit recheck, mid-bit sampling, parity/stop check
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '1;
            rx_act   <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_pe    <= 1'b0;
            rx_msb   <= 1'b0;
            rx_par   <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            sync     <= {sync[1:0], rxd};
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (!rx_act) begin
                if (rx_fall) begin
                    rx_act <= 1'b1;
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_pe  <= parity_en;
                    rx_msb <= msb_first;
                end
            end else begin
                rx_cnt <= rx_cnt == LAST ? '0 : rx_cnt + 1'b1;
                rx_bit <= rx_cnt == LAST ? rx_bit + 1'b1 : rx_bit;
                if (rx_cnt == HALF) begin
                    if (rx_bit == 4'd0)
                        rx_act <= !rx_s;
                    else if (rx_bit <= 4'd8)
                        rx_sh <= rx_msb ? {rx_sh[6:0], rx_s} : {rx_s, rx_sh[7:1]};
                    else if (!rx_stop)
                        rx_par <= rx_s;
                    else begin
                        rx_act   <= 1'b0;
                        rx_valid <= rx_ok;
                        rx_err   <= !rx_ok;
                    end
                end
            end
        end
    end

    // transmitter: load a whole frame into a shifter; a new frame may load in the last stop cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_act <= 1'b0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_nb  <= '0;
            tx_sh  <= '1;
        end else if (tx_start && tx_ready) begin
            tx_act <= 1'b1;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_nb  <= parity_en ? 4'd10 : 4'd9;
            tx_sh  <= {1'b1, !parity_en || ^tx_data, msb_first ? rev8(tx_data) : tx_data, 1'b0};
        end else if (tx_act) begin
            tx_cnt <= tx_cnt == LAST ? '0 : tx_cnt + 1'b1;
            if (tx_cnt == LAST) begin
                tx_bit <= tx_bit + 1'b1;
                tx_sh  <= {1'b1, tx_sh[10:1]};
                tx_act <= !tx_done;
            end
        end
    end

endmodule

// File: rtl/uart_harness.sv
// uart_harness: UART command bridge performing burst writes/reads on a 16-bit register stub
module uart_harness
    import uart_harness_pkg::*;
#(
    parameter logic [3:0] BASEADDR = 4'h2,
    parameter int         CLK_DIV  = 16,
    parameter int         REG_NUM  = 32,
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic txd,
    input  logic parity_en,
    input  logic msb_first,
    output logic busy
);
    localparam int AW = $clog2(REG_NUM);

    state_t      state;
    logic        is_wr, hit, tx_req, lo_next;
    logic [3:0]  len, idx;
    logic [15:0] addr;
    logic [7:0]  wr_hi, tx_byte, rx_data;
    logic        rx_valid, rx_err, tx_ready, tx_done, tx_take, base_ok;
    logic [11:0] cur_off, first_off, next_off;
    logic [15:0] cur_word, first_word, next_word;
    logic [15:0] regs [REG_NUM];

    function automatic logic in_range(input logic [11:0] o);
        return int'(o) < REG_NUM;
    endfunction

    assign tx_take    = tx_req && tx_ready;
    assign base_ok    = addr[15:12] == BASEADDR;
    assign cur_off    = addr[11:0] + 12'(idx);
    assign first_off  = {addr[11:8], rx_data};
    assign next_off   = cur_off + 12'd1;
    assign cur_word   = in_range(cur_off) ? regs[cur_off[AW-1:0]] : 16'h0000;
    assign first_word = in_range(first_off) ? regs[first_off[AW-1:0]] : 16'h0000;
    assign next_word  = in_range(next_off) ? regs[next_off[AW-1:0]] : 16'h0000;

    uart_harness_phy #(.CLK_DIV(CLK_DIV)) phy (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .parity_en(parity_en),
        .msb_first(msb_first),
        .tx_start (tx_req),
        .tx_data  (tx_byte),
        .txd      (txd),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_data  (rx_data)
    );

    // command FSM, register stub and response sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            is_wr   <= 1'b0;
            hit     <= 1'b0;
            tx_req  <= 1'b0;
            lo_next <= 1'b0;
            len     <= '0;
            idx     <= '0;
            addr    <= '0;
            wr_hi   <= '0;
            tx_byte <= '0;
            for (int i = 0; i < REG_NUM; i++) regs[i] <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: if (rx_valid) begin
                    is_wr <= rx_data[CMD_RW_BIT];
                    len   <= rx_data[CMD_LEN_MSB:CMD_LEN_LSB];
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= S_ADDR_H;
                end
                S_ADDR_H: if (rx_err) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else if (rx_valid) begin
                    addr[15:8] <= rx_data;
                    state      <= S_ADDR_L;
                end
                S_ADDR_L: if (rx_err) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else if (rx_valid) begin
                    addr[7:0] <= rx_data;
                    hit       <= base_ok;
                    if (is_wr)
                        state <= S_WDATA_H;
                    else if (base_ok) begin
                        state   <= S_RD_SEND;
                        tx_req  <= 1'b1;
                        tx_byte <= first_word[15:8];
                        lo_next <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_WDATA_H: if (rx_err) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else if (rx_valid) begin
                    wr_hi <= rx_data;
                    state <= S_WDATA_L;
                end
                S_WDATA_L: if (rx_err) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else if (rx_valid) begin
                    if (hit && in_range(cur_off)) regs[cur_off[AW-1:0]] <= {wr_hi, rx_data};
                    if (idx != len) begin
                        idx   <= idx + 1'b1;
                        state <= S_WDATA_H;
                    end else if (hit) begin
                        state   <= S_ACK_SEND;
                        tx_req  <= 1'b1;
                        tx_byte <= ACK_BYTE;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_RD_SEND: begin
                    if (tx_take) begin
                        if (lo_next) begin
                            tx_byte <= cur_word[7:0];
                            lo_next <= 1'b0;
                        end else if (idx == len)
                            tx_req <= 1'b0;
                        else begin
                            idx     <= idx + 1'b1;
                            tx_byte <= next_word[15:8];
                            lo_next <= 1'b1;
                        end
                    end
                    if (tx_done && !tx_req) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_ACK_SEND: begin
                    if (tx_take) tx_req <= 1'b0;
                    if (tx_done && !tx_req) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_harness.sv
// tb_uart_harness: table-driven and randomized checks of the UART register bridge
module tb_uart_harness;
    localparam int CLK_DIV = 8;
    localparam int REG_NUM = 32;

    typedef struct packed {
        logic         wr;
        logic [3:0]   len;
        logic [15:0]  addr;
        logic [255:0] w;
        logic         pe;
        logic         msb;
        logic [7:0]   exp_n;
        logic [7:0]   exp_b0;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, parity_en = 1'b0, msb_first = 1'b0;
    logic txd, busy;
    logic cfg_pe = 1'b0, cfg_msb = 1'b0;
    int checks = 0, errors = 0;
    logic [8:0]  got_q[$];
    logic [15:0] model [REG_NUM];

    uart_harness #(.BASEADDR(4'h2), .CLK_DIV(CLK_DIV), .REG_NUM(REG_NUM), .ACK_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
        .parity_en(parity_en), .msb_first(msb_first), .busy(busy)
    );

    always #5 clk = ~clk;

    // serial monitor: decodes txd characters with the current format, recording data and frame validity
    initial begin : mon
        logic prev, ok;
        logic [7:0] d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !txd && !rst) begin
                repeat (CLK_DIV / 2 - 1) @(negedge clk);
                ok = !txd;
                d  = '0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    d[cfg_msb ? 7 - i : i] = txd;
                end
                if (cfg_pe) begin
                    repeat (CLK_DIV) @(negedge clk);
                    ok = ok & (txd == ^d);
                end
                repeat (CLK_DIV) @(negedge clk);
                ok = ok & txd;
                got_q.push_back({ok, d});
            end
            prev = txd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        parity_en = cfg_pe;
        msb_first = cfg_msb;
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[cfg_msb ? 7 - i : i];
            repeat (CLK_DIV) @(negedge clk);
        end
        if (cfg_pe) begin
            rxd = ^b ^ bad_par;
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    // one full command: update the model, send the frame, then compare every returned byte
    task automatic run_txn(input logic wr, input logic [3:0] len, input logic [15:0] addr,
                           input logic [255:0] w, input logic pe, input logic msb,
                           output int n, output logic [7:0] b0);
        logic [7:0]  exp_q[$];
        logic [11:0] off;
        logic [15:0] m;
        logic        hit;
        int          t, lim;
        cfg_pe  = pe;
        cfg_msb = msb;
        got_q.delete();
        hit = addr[15:12] == 4'h2;
        for (int i = 0; i <= int'(len); i++) begin
            off = addr[11:0] + 12'(i);
            if (wr) begin
                if (hit && int'(off) < REG_NUM) model[off[4:0]] = w[i*16 +: 16];
            end else if (hit) begin
                m = int'(off) < REG_NUM ? model[off[4:0]] : 16'h0000;
                exp_q.push_back(m[15:8]);
                exp_q.push_back(m[7:0]);
            end
        end
        if (wr && hit) exp_q.push_back(8'hA5);
        send_byte({wr, 3'($urandom), len}, 1'b0);
        send_byte(addr[15:8], 1'b0);
        send_byte(addr[7:0], 1'b0);
        if (wr)
            for (int i = 0; i <= int'(len); i++) begin
                send_byte(w[i*16+8 +: 8], 1'b0);
                send_byte(w[i*16 +: 8], 1'b0);
            end
        lim = (exp_q.size() + 2) * 12 * CLK_DIV;
        t = 0;
        while (busy && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("busy_release", 32'(busy), 0);
        repeat (14 * CLK_DIV) @(negedge clk);
        chk("resp_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("resp_byte%0d", i), 32'(got_q[i][7:0]), 32'(exp_q[i]));
            chk($sformatf("resp_frame%0d", i), 32'(got_q[i][8]), 1);
        end
        n  = got_q.size();
        b0 = n > 0 ? got_q[0][7:0] : 8'h00;
    endtask

    function automatic vec_t mk(input logic wr, input logic [3:0] len, input logic [15:0] addr,
                                input logic [255:0] w, input logic pe, input logic msb,
                                input logic [7:0] en, input logic [7:0] eb);
        return {wr, len, addr, w, pe, msb, en, eb};
    endfunction

    initial begin
        vec_t         tbl[17];
        logic [255:0] burst, rw;
        logic [15:0]  ra;
        logic [3:0]   rl;
        logic [7:0]   b0;
        int           n;
        for (int i = 0; i < 16; i++) burst[i*16 +: 16] = i < 15 ? 16'(i + 1) * 16'h1111 : 16'hABCD;
        tbl[0]  = mk(1, 0,  16'h2008, 256'h8888,      1, 1, 1,  8'hA5);
        tbl[1]  = mk(0, 0,  16'h2008, 256'h0,         1, 1, 2,  8'h88);
        tbl[2]  = mk(1, 15, 16'h2001, burst,          1, 1, 1,  8'hA5);
        tbl[3]  = mk(0, 15, 16'h2001, 256'h0,         1, 1, 32, 8'h11);
        tbl[4]  = mk(1, 0,  16'h200A, 256'hC3A1,      0, 0, 1,  8'hA5);
        tbl[5]  = mk(0, 0,  16'h200A, 256'h0,         0, 0, 2,  8'hC3);
        tbl[6]  = mk(1, 0,  16'h200B, 256'h1E2D,      0, 1, 1,  8'hA5);
        tbl[7]  = mk(0, 0,  16'h200B, 256'h0,         0, 1, 2,  8'h1E);
        tbl[8]  = mk(1, 0,  16'h200C, 256'hF00F,      1, 0, 1,  8'hA5);
        tbl[9]  = mk(0, 0,  16'h200C, 256'h0,         1, 0, 2,  8'hF0);
        tbl[10] = mk(1, 0,  16'h3008, 256'h1234,      1, 1, 0,  8'h00);
        tbl[11] = mk(0, 0,  16'h3008, 256'h0,         1, 1, 0,  8'h00);
        tbl[12] = mk(0, 0,  16'h2008, 256'h0,         1, 1, 2,  8'h88);
        tbl[13] = mk(0, 1,  16'h201F, 256'h0,         0, 1, 4,  8'h00);
        tbl[14] = mk(1, 1,  16'h2FFF, 256'h4242_7777, 1, 0, 1,  8'hA5);
        tbl[15] = mk(0, 0,  16'h2000, 256'h0,         1, 0, 2,  8'h42);
        tbl[16] = mk(0, 1,  16'h2FFF, 256'h0,         1, 1, 4,  8'h00);
        for (int i = 0; i < REG_NUM; i++) model[i] = 16'h0000;

        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 1);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            run_txn(tbl[i].wr, tbl[i].len, tbl[i].addr, tbl[i].w, tbl[i].pe, tbl[i].msb, n, b0);
            chk($sformatf("row%0d_n", i), n, 32'(tbl[i].exp_n));
            if (tbl[i].exp_n > 0) chk($sformatf("row%0d_b0", i), 32'(b0), 32'(tbl[i].exp_b0));
        end

        // corrupted parity on ADDR_L aborts the frame
        cfg_pe  = 1'b1;
        cfg_msb = 1'b1;
        got_q.delete();
        send_byte(8'h80, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b1);
        repeat (4) @(negedge clk);
        chk("parerr_busy", 32'(busy), 0);
        repeat (14 * CLK_DIV) @(negedge clk);
        chk("parerr_silent", got_q.size(), 0);
        run_txn(0, 0, 16'h2008, 256'h0, 1, 1, n, b0);
        chk("parerr_read_n", n, 2);

        // short low pulse on rxd is a glitch, not a start bit
        got_q.delete();
        parity_en = 1'b0;
        msb_first = 1'b0;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        chk("glitch_busy", 32'(busy), 0);
        chk("glitch_silent", got_q.size(), 0);

        // randomized write-then-read pairs against the model
        for (int k = 0; k < 6; k++) begin
            ra[15:12] = $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'h2;
            ra[11:0]  = $urandom_range(0, 3) == 0 ? 12'hFFC + 12'($urandom_range(0, 3))
                                                  : 12'($urandom_range(0, 40));
            rl = 4'($urandom_range(0, 4));
            for (int j = 0; j < 16; j++) rw[j*16 +: 16] = 16'($urandom);
            run_txn(1'b1, rl, ra, rw, 1'($urandom), 1'($urandom), n, b0);
            run_txn(1'b0, rl, ra, 256'h0, 1'($urandom), 1'($urandom), n, b0);
        end

        // reset in the middle of a write burst clears everything
        cfg_pe  = 1'b1;
        cfg_msb = 1'b0;
        send_byte(8'h83, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'h12, 1'b0);
        chk("burst_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_txd", 32'(txd), 1);
        rst = 1'b0;
        for (int i = 0; i < REG_NUM; i++) model[i] = 16'h0000;
        repeat (2) @(negedge clk);
        run_txn(0, 1, 16'h200F, 256'h0, 1, 0, n, b0);
        chk("rst_read_n", n, 4);
        run_txn(0, 0, 16'h2008, 256'h0, 0, 1, n, b0);
        chk("rst_read_b0", 32'(b0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
